alu_seq16: RTL and testbench

- Multi-cycle sequencer that drives the shared 8-bit 74181-style ALU (4-bit op, mode, active-low add carry / active-high borrow) to perform 16-bit operations and an 8x8 unsigned multiply.
- Sits between the microcode/control unit and the ALU.
- Owns the ALU input ports while busy, chains carry/borrow between byte passes, and returns a registered result with a done pulse.

---
 rtl/alu_seq_pkg.sv | 21 ++
 rtl/alu_seq16.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq16.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq16 byte-pass sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic       CMD_OP16       = 1'b0;
    localparam logic       CMD_MUL8       = 1'b1;

    localparam logic [3:0] ALU_OP_ADD     = 4'b1001;
    localparam logic [3:0] ALU_OP_SUB     = 4'b0110;

    // Raw ALU carry-in level meaning "no carry" on an add.
    localparam logic       ALU_CF_NOCARRY = 1'b1;

endpackage

// File: rtl/alu_seq16.sv
// alu_seq16: drives the shared 8-bit 74181-style ALU through two byte passes
// for a 16-bit operation, or eight shift-add passes for an 8x8 multiply.
// Optional build macro ALU_SEQ_MUL_EN enables the MUL8 command; without it
// cmd is ignored and every start runs the 16-bit op path.
module alu_seq16
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cmd,
    input  logic [3:0]  op,
    input  logic        mode,
    input  logic        cin,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cf_out,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cf_in,
    output logic [3:0]  alu_op,
    output logic        alu_mode,
    input  logic [7:0]  alu_out,
    input  logic        alu_cf_out
);

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        mode_q, mode_d;
    logic        cin_q, cin_d;
    logic        c_q, c_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic [15:0] result_q, result_d;
    logic        cf_q, cf_d;

`ifdef ALU_SEQ_MUL_EN
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  acc_hi_q, acc_hi_d;
    logic [7:0]  acc_lo_q, acc_lo_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  mul_sum;
    logic        mul_k;
`else
    logic        unused_cmd;
    assign unused_cmd = cmd;
`endif

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cf_out = cf_q;

    // Next-state and datapath register updates for each sequencer state.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        mode_d   = mode_q;
        cin_d    = cin_q;
        c_d      = c_q;
        res_lo_d = res_lo_q;
        result_d = result_q;
        cf_d     = cf_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        // Add the multiplicand only when the current multiplier bit is set;
        // the ALU carry is active-low, so invert it to get the 9th sum bit.
        mul_sum  = acc_lo_q[0] ? alu_out : acc_hi_q;
        mul_k    = acc_lo_q[0] ? ~alu_cf_out : 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = opa;
                    b_d    = opb;
                    op_d   = op;
                    mode_d = mode;
                    cin_d  = cin;
                    state_d = LO;
`ifdef ALU_SEQ_MUL_EN
                    if (cmd == CMD_MUL8) begin
                        state_d  = MUL;
                        cnt_d    = 3'd0;
                        acc_hi_d = 8'd0;
                        acc_lo_d = opb[7:0];
                        mcand_d  = opa[7:0];
                    end
`endif
                end
            end
            LO: begin
                res_lo_d = alu_out;
                c_d      = alu_cf_out;
                state_d  = HI;
            end
            HI: begin
                result_d = {alu_out, res_lo_q};
                cf_d     = alu_cf_out;
                state_d  = DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                {acc_hi_d, acc_lo_d} = {mul_k, mul_sum, acc_lo_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = {mul_k, mul_sum, acc_lo_q[7:1]};
                    cf_d     = 1'b0;
                    state_d  = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU port drive: owned only during LO/HI/MUL, parked at zero otherwise.
    always_comb begin
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_cf_in = 1'b0;
        alu_op    = 4'd0;
        alu_mode  = 1'b0;
        case (state_q)
            LO: begin
                alu_a     = a_q[7:0];
                alu_b     = b_q[7:0];
                alu_cf_in = cin_q;
                alu_op    = op_q;
                alu_mode  = mode_q;
            end
            HI: begin
                // Raw carry from the low pass chains correctly for add and sub.
                alu_a     = a_q[15:8];
                alu_b     = b_q[15:8];
                alu_cf_in = c_q;
                alu_op    = op_q;
                alu_mode  = mode_q;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                alu_a     = acc_hi_q;
                alu_b     = mcand_q;
                alu_cf_in = ALU_CF_NOCARRY;
                alu_op    = ALU_OP_ADD;
                alu_mode  = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // State and datapath registers with synchronous reset (aborts any pass).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            c_q      <= 1'b0;
            res_lo_q <= '0;
            result_q <= '0;
            cf_q     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            mode_q   <= mode_d;
            cin_q    <= cin_d;
            c_q      <= c_d;
            res_lo_q <= res_lo_d;
            result_q <= result_d;
            cf_q     <= cf_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Testbench for alu_seq16 with a behavioural 74181-style ALU attached.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cmd;
    logic [3:0]  op;
    logic        mode;
    logic        cin;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cf_out;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cf_in;
    logic [3:0]  alu_op;
    logic        alu_mode;
    logic [7:0]  alu_out;
    logic        alu_cf_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        cmd;
        logic [3:0]  op;
        logic        mode;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_cf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    alu_seq16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .op         (op),
        .mode       (mode),
        .cin        (cin),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cf_out     (cf_out),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cf_in  (alu_cf_in),
        .alu_op     (alu_op),
        .alu_mode   (alu_mode),
        .alu_out    (alu_out),
        .alu_cf_out (alu_cf_out)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: active-low carry in/out; add = A+B+~cf, sub = A+~B+~cf.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum    = 9'd0;
        alu_out    = 8'd0;
        alu_cf_out = 1'b1;
        if (alu_mode) begin
            case (alu_op)
                4'b0110: alu_out = alu_a ^ alu_b;
                4'b1011: alu_out = alu_a & alu_b;
                4'b1110: alu_out = alu_a | alu_b;
                default: alu_out = ~alu_a;
            endcase
        end else begin
            case (alu_op)
                4'b1001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b}  + {8'd0, ~alu_cf_in};
                4'b0110: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, ~alu_cf_in};
                default: alu_sum = {1'b0, alu_a} + {8'd0, ~alu_cf_in};
            endcase
            alu_out    = alu_sum[7:0];
            alu_cf_out = ~alu_sum[8];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic c, input logic [3:0] o,
                                input logic m, input logic ci, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] r,
                                input logic cf, input int lat);
        vec_t v;
        v.name = name; v.cmd = c; v.op = o; v.mode = m; v.cin = ci;
        v.a = a; v.b = b; v.exp_res = r; v.exp_cf = cf; v.exp_lat = lat;
        return v;
    endfunction

    // Present a command for one cycle; returns at the falling edge of cycle 1.
    task automatic launch(input vec_t v);
        cmd = v.cmd; op = v.op; mode = v.mode; cin = v.cin;
        opa = v.a; opb = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count cycles until done, bounded so a stuck sequencer cannot hang the run.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        launch(v);
        wait_done(lat);
        check({v.name, "_latency"}, lat, v.exp_lat);
        check({v.name, "_result"}, result, v.exp_res);
        check({v.name, "_cf"}, cf_out, v.exp_cf);
        @(negedge clk);
        check({v.name, "_done_pulse"}, {busy, done}, 2'b00);
        check({v.name, "_hold"}, result, v.exp_res);
    endtask

    initial begin
        int ndone;
        vec_t v;

        vecs.push_back(mk("add_carry",    1'b0, 4'b1001, 1'b0, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b1, 3));
        vecs.push_back(mk("add_overflow", 1'b0, 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3));
        vecs.push_back(mk("sub_borrow",   1'b0, 4'b0110, 1'b0, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 3));
        vecs.push_back(mk("sub_wrap",     1'b0, 4'b0110, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 3));
        vecs.push_back(mk("logic_xor",    1'b0, 4'b0110, 1'b1, 1'b0, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b1, 3));
        vecs.push_back(mk("add_cin",      1'b0, 4'b1001, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5556, 1'b1, 3));
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back(mk("mul_ff_ff",    1'b1, 4'b0000, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 9));
        vecs.push_back(mk("mul_zero",     1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 16'h0037, 16'h0000, 1'b0, 9));
        vecs.push_back(mk("mul_upper",    1'b1, 4'b0000, 1'b0, 1'b0, 16'hAB0D, 16'hCD0B, 16'h008F, 1'b0, 9));
`else
        vecs.push_back(mk("cmd1_as_op16", 1'b1, 4'b1001, 1'b0, 1'b1, 16'h0102, 16'h0304, 16'h0406, 1'b1, 3));
`endif

        rst = 1'b1; start = 1'b0; cmd = 1'b0; op = 4'd0; mode = 1'b0; cin = 1'b0;
        opa = 16'd0; opb = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy, done, cf_out}, 3'b000);
        check("reset_result", result, 16'h0000);
        check("reset_alu", {alu_a, alu_b, alu_cf_in, alu_op, alu_mode}, 22'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // start held high through LO/HI/DONE must not restart the sequencer
        cmd = 1'b0; op = 4'b1001; mode = 1'b0; cin = 1'b1;
        opa = 16'h0101; opb = 16'h0202; start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (cyc == 1) begin opa = 16'hFFFF; opb = 16'h0001; end
            if (cyc == 4) start = 1'b0;
        end
        check("busy_ignore_done_count", ndone, 1);
        check("busy_ignore_result", result, 16'h0303);
        check("busy_ignore_idle", busy, 1'b0);

        // reset asserted during the high pass aborts without a done pulse
        v = mk("post_reset", 1'b0, 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0101, 16'h0200, 1'b1, 3);
        launch(mk("abort", 1'b0, 4'b1001, 1'b0, 1'b1, 16'h12FF, 16'h0001, 16'h1300, 1'b1, 3));
        @(negedge clk);
        check("abort_in_hi", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {busy, done, cf_out}, 3'b000);
        check("abort_result", result, 16'h0000);
        rst = 1'b0;
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
